// File: rtl/core_step_ctrl.sv
// Purpose: divides clk_i into core ticks and gates the core clock enable through
//          power-on reset hold, run/halt/single-step debug control and a PC breakpoint.
// Latency: all outputs registered; control inputs take effect on the next clk_i edge.
// Backpressure: none; halt_i and breakpoint hits simply suppress core_ce_o pulses.
//
// Ports:
//   clk_i        system clock (single domain)
//   reset_i      asynchronous active-low reset
//   run_i        resume request (level, sampled every cycle)
//   halt_i       halt request (level, highest priority)
//   step_i       single-step request (level)
//   bp_en_i      breakpoint enable
//   bp_addr_i    breakpoint PC
//   pc_i         core's current PC
//   core_ce_o    one-cycle core clock enable, only in tick cycles
//   core_rst_o   synchronous active-high reset to the core
//   halted_o     1 while in HALT
//   state_o      RST=0, RUN=1, HALT=2, STEP=3
//   cycle_cnt_o  core_ce_o pulses issued in RUN or STEP (wraps)
module core_step_ctrl #(
  parameter int CLK_FREQ     = 100000000,
  parameter int CORE_FREQ    = 1000000,
  parameter int RST_TICKS    = 4,
  parameter int START_HALTED = 0
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        run_i,
  input  logic        halt_i,
  input  logic        step_i,
  input  logic        bp_en_i,
  input  logic [31:0] bp_addr_i,
  input  logic [31:0] pc_i,
  output logic        core_ce_o,
  output logic        core_rst_o,
  output logic        halted_o,
  output logic [1:0]  state_o,
  output logic [31:0] cycle_cnt_o
);

  localparam int DIV = CLK_FREQ / CORE_FREQ;
  // A one-bit prescaler is kept even for DIV=1 so the compare below stays legal.
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int RW  = $clog2(RST_TICKS + 1);

  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
  localparam logic [RW-1:0] RST_LAST  = RW'(RST_TICKS);

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2,
    ST_STEP = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic [RW-1:0]  rst_cnt_q, rst_cnt_d;
  logic           skip_bp_q, skip_bp_d;
  logic           core_ce_q, core_ce_d;
  logic           core_rst_q, core_rst_d;
  logic           halted_q, halted_d;
  logic [31:0]    cycle_cnt_q, cycle_cnt_d;

  logic           tick;
  logic           bp_hit;
  logic           cnt_inc;

  always_comb begin
    // tick marks the edge that ends the DIV-th cycle of each period; the tick
    // cycle itself is the one following this edge, so core_ce is registered here.
    tick       = (presc_q == PRESC_MAX);
    presc_d    = tick ? '0 : presc_q + 1'b1;
    bp_hit     = bp_en_i && (pc_i == bp_addr_i) && !skip_bp_q;

    state_d    = state_q;
    rst_cnt_d  = rst_cnt_q;
    skip_bp_d  = skip_bp_q;
    core_ce_d  = 1'b0;
    cnt_inc    = 1'b0;

    case (state_q)
      ST_RST: begin
        // Leave RST one edge after the last reset tick, so the core sees
        // core_rst=1 together with its final enable pulse.
        if (rst_cnt_q == RST_LAST) begin
          state_d = (START_HALTED != 0) ? ST_HALT : ST_RUN;
        end else if (tick) begin
          core_ce_d = 1'b1;
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (halt_i) begin
          state_d = ST_HALT;
        end else if (tick) begin
          // The first tick after a resume consumes the skip, whether or not
          // the PC still matches the breakpoint.
          skip_bp_d = 1'b0;
          if (bp_hit) begin
            state_d = ST_HALT;
          end else begin
            core_ce_d = 1'b1;
            cnt_inc   = 1'b1;
          end
        end
      end
      ST_HALT: begin
        if (halt_i) begin
          state_d = ST_HALT;
        end else if (step_i) begin
          state_d = ST_STEP;
        end else if (run_i) begin
          state_d   = ST_RUN;
          skip_bp_d = 1'b1;
        end
      end
      ST_STEP: begin
        if (halt_i) begin
          state_d = ST_HALT;
        end else if (tick) begin
          core_ce_d = 1'b1;
          cnt_inc   = 1'b1;
          state_d   = ST_HALT;
        end
      end
      default: begin
        state_d = ST_RST;
      end
    endcase

    cycle_cnt_d = cnt_inc ? cycle_cnt_q + 32'd1 : cycle_cnt_q;
    core_rst_d  = (state_d == ST_RST);
    halted_d    = (state_d == ST_HALT);
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= ST_RST;
      presc_q     <= '0;
      rst_cnt_q   <= '0;
      skip_bp_q   <= 1'b0;
      core_ce_q   <= 1'b0;
      core_rst_q  <= 1'b1;
      halted_q    <= 1'b0;
      cycle_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      rst_cnt_q   <= rst_cnt_d;
      skip_bp_q   <= skip_bp_d;
      core_ce_q   <= core_ce_d;
      core_rst_q  <= core_rst_d;
      halted_q    <= halted_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign core_ce_o   = core_ce_q;
  assign core_rst_o  = core_rst_q;
  assign halted_o    = halted_q;
  assign state_o     = state_q;
  assign cycle_cnt_o = cycle_cnt_q;

endmodule
